char_anim_state_controller: RTL and testbench



---
 rtl/char_anim_pkg.sv | 45 ++++
 rtl/char_anim_fsm.sv | 169 ++++++++++++++++
 rtl/char_anim_state_controller.sv | 78 +++++++
 tb/tb_char_anim_state_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_anim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_anim_pkg
// Description : Shared encodings for the character animation controller:
//               physics state codes, sprite display ids and a helper that
//               sizes the internal tick counters.
// Revision    : 1.0 - initial multi-character release
// ============================================================================
package char_anim_pkg;

    // Physics state codes arriving from the character FSMs
    typedef enum logic [2:0] {
        CS_IDLE           = 3'd0,
        CS_LEFT           = 3'd1,
        CS_RIGHT          = 3'd2,
        CS_CHARGE         = 3'd3,
        CS_JUMP           = 3'd4,
        CS_COLLISION      = 3'd5,
        CS_FALL_TO_GROUND = 3'd6,
        CS_HOLD           = 3'd7
    } char_state_e;

    // Sprite ids handed to the renderer
    typedef enum logic [2:0] {
        ID_IDLE_1    = 3'd0,
        ID_IDLE_2    = 3'd1,
        ID_CHARGE    = 3'd2,
        ID_JUMP_UP   = 3'd3,
        ID_JUMP_DOWN = 3'd4,
        ID_HARD_LAND = 3'd5,
        ID_SOFT_LAND = 3'd6,
        ID_WALK      = 3'd7
    } disp_id_e;

    // Counter width large enough to hold the largest period value
    function automatic int cnt_width_f(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_anim_fsm.sv
`default_nettype none
// ============================================================================
// Module      : char_anim_fsm
// Description : One animation channel. On each tick turns the registered
//               physics state and vertical velocity into a sprite id, a walk
//               frame bit and a facing bit, with breathing, landing-hold and
//               walk counters.
// Ports       : clk_i, rst_ni (async, active-low), tick_i (1-cycle strobe),
//               state_i (physics state), vel_i (signed, positive = up),
//               id_o, walk_frame_o, facing_left_o
// Config      : CHAR_ANIM_LAND_CANCEL_EN - CHARGE aborts a landing hold
// Revision    : 1.0 - initial multi-character release
// ============================================================================
module char_anim_fsm
    import char_anim_pkg::*;
#(
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int IDLE_PERIOD      = 64,
    parameter int LAND_HOLD_TICKS  = 64,
    parameter int WALK_FRAME_TICKS = 8,
    parameter int HARD_LAND_VEL    = 7,
    parameter int CNT_WIDTH        = 7
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               tick_i,
    input  logic [2:0]                         state_i,
    input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_i,
    output logic [2:0]                         id_o,
    output logic                               walk_frame_o,
    output logic                               facing_left_o
);

    localparam logic [CNT_WIDTH-1:0] c_IDLE_LAST = CNT_WIDTH'(IDLE_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] c_IDLE_HALF = CNT_WIDTH'(IDLE_PERIOD / 2);
    localparam logic [CNT_WIDTH-1:0] c_LAND_LAST = CNT_WIDTH'(LAND_HOLD_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] c_WALK_LAST = CNT_WIDTH'(WALK_FRAME_TICKS - 1);
    // Hard-landing threshold, sign-extended so the compare below is signed
    localparam logic signed [SIGNED_PHY_WIDTH-1:0] c_HARD_THR =
        -$signed(SIGNED_PHY_WIDTH'(HARD_LAND_VEL));

    disp_id_e                            id_q, id_d, w_next_id;
    logic [CNT_WIDTH-1:0]                idle_cnt_q, idle_cnt_d;
    logic [CNT_WIDTH-1:0]                land_cnt_q, land_cnt_d;
    logic [CNT_WIDTH-1:0]                walk_cnt_q, walk_cnt_d;
    logic                                walk_frame_q, walk_frame_d;
    logic                                facing_q, facing_d, w_facing_nxt;
    logic signed [SIGNED_PHY_WIDTH-1:0]  vel_land_q, vel_land_d;
    logic                                w_vel_pos, w_vel_neg;
    logic                                w_cur_idle, w_cur_land, w_land_hold;
    logic                                w_nxt_idle, w_nxt_land;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q         <= ID_IDLE_1;
            idle_cnt_q   <= '0;
            land_cnt_q   <= '0;
            walk_cnt_q   <= '0;
            walk_frame_q <= 1'b0;
            facing_q     <= 1'b0;
            vel_land_q   <= '0;
        end else begin
            id_q         <= id_d;
            idle_cnt_q   <= idle_cnt_d;
            land_cnt_q   <= land_cnt_d;
            walk_cnt_q   <= walk_cnt_d;
            walk_frame_q <= walk_frame_d;
            facing_q     <= facing_d;
            vel_land_q   <= vel_land_d;
        end
    end

    always_comb begin
        id_d         = id_q;
        idle_cnt_d   = idle_cnt_q;
        land_cnt_d   = land_cnt_q;
        walk_cnt_d   = walk_cnt_q;
        walk_frame_d = walk_frame_q;
        facing_d     = facing_q;
        vel_land_d   = vel_land_q;
        w_next_id    = id_q;
        w_facing_nxt = facing_q;

        w_vel_neg   = vel_i[SIGNED_PHY_WIDTH-1];
        w_vel_pos   = !vel_i[SIGNED_PHY_WIDTH-1] && (vel_i != '0);
        w_cur_idle  = (id_q == ID_IDLE_1) || (id_q == ID_IDLE_2);
        w_cur_land  = (id_q == ID_HARD_LAND) || (id_q == ID_SOFT_LAND);
        w_land_hold = w_cur_land && (land_cnt_q < c_LAND_LAST);

        case (char_state_e'(state_i))
            CS_IDLE: begin
                if (w_land_hold)    w_next_id = id_q;
                else if (w_vel_pos) w_next_id = ID_JUMP_UP;
                else if (w_vel_neg) w_next_id = ID_JUMP_DOWN;
                else if (idle_cnt_q < c_IDLE_HALF) w_next_id = ID_IDLE_1;
                else                w_next_id = ID_IDLE_2;
            end
            CS_LEFT: begin
                w_next_id    = ID_WALK;
                w_facing_nxt = 1'b1;
            end
            CS_RIGHT: begin
                w_next_id    = ID_WALK;
                w_facing_nxt = 1'b0;
            end
            CS_CHARGE: begin
`ifdef CHAR_ANIM_LAND_CANCEL_EN
                w_next_id = ID_CHARGE;
`else
                w_next_id = w_land_hold ? id_q : ID_CHARGE;
`endif
            end
            CS_JUMP, CS_COLLISION: begin
                if (w_vel_pos)      w_next_id = ID_JUMP_UP;
                else if (w_vel_neg) w_next_id = ID_JUMP_DOWN;
            end
            CS_FALL_TO_GROUND: begin
                // Decided from the last nonzero velocity seen before this tick
                if (vel_land_q != '0) begin
                    w_next_id = (vel_land_q < c_HARD_THR) ? ID_HARD_LAND : ID_SOFT_LAND;
                end
            end
            default: w_next_id = id_q;
        endcase

        w_nxt_idle = (w_next_id == ID_IDLE_1) || (w_next_id == ID_IDLE_2);
        w_nxt_land = (w_next_id == ID_HARD_LAND) || (w_next_id == ID_SOFT_LAND);

        if (tick_i) begin
            id_d     = w_next_id;
            facing_d = w_facing_nxt;

            // Breathing phase counts ticks already spent idle; entering idle
            // starts from zero so it always opens with IDLE_1.
            if (w_nxt_idle && w_cur_idle)
                idle_cnt_d = (idle_cnt_q == c_IDLE_LAST) ? '0 : idle_cnt_q + 1'b1;
            else
                idle_cnt_d = '0;

            // Landing hold starts at zero on the tick the pose is entered
            if (w_nxt_land && w_cur_land)
                land_cnt_d = (land_cnt_q == c_LAND_LAST) ? land_cnt_q : land_cnt_q + 1'b1;
            else
                land_cnt_d = '0;

            // Walk counts the entering tick, so the first frame flip lands
            // after exactly WALK_FRAME_TICKS ticks of walking.
            if (w_next_id == ID_WALK) begin
                if (walk_cnt_q == c_WALK_LAST) begin
                    walk_cnt_d   = '0;
                    walk_frame_d = !walk_frame_q;
                end else begin
                    walk_cnt_d   = walk_cnt_q + 1'b1;
                end
            end else begin
                walk_cnt_d   = '0;
                walk_frame_d = 1'b0;
            end

            if (vel_i != '0) vel_land_d = vel_i;
        end
    end

    assign id_o          = id_q;
    assign walk_frame_o  = walk_frame_q;
    assign facing_left_o = facing_q;

endmodule
`default_nettype wire

// File: rtl/char_anim_state_controller.sv
`default_nettype none
// ============================================================================
// Module      : char_anim_state_controller
// Description : NUM_CHAR independent sprite animation channels advanced by a
//               rising-edge detect of the character_clk strobe.
// Ports       : sys_clk, sys_rst_n (async, active-low), character_clk,
//               char_state[3*NUM_CHAR], vel_y[SIGNED_PHY_WIDTH*NUM_CHAR],
//               char_display_id[3*NUM_CHAR], walk_frame[NUM_CHAR],
//               facing_left[NUM_CHAR]
// Config      : CHAR_ANIM_LAND_CANCEL_EN - CHARGE aborts a landing hold
// Revision    : 1.0 - initial multi-character release
// ============================================================================
module char_anim_state_controller
    import char_anim_pkg::*;
#(
    parameter int NUM_CHAR         = 2,
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int IDLE_PERIOD      = 64,
    parameter int LAND_HOLD_TICKS  = 64,
    parameter int WALK_FRAME_TICKS = 8,
    parameter int HARD_LAND_VEL    = 7,
    parameter int CNT_WIDTH        = cnt_width_f(IDLE_PERIOD, LAND_HOLD_TICKS, WALK_FRAME_TICKS)
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic                                 character_clk,
    input  logic [3*NUM_CHAR-1:0]                char_state,
    input  logic [SIGNED_PHY_WIDTH*NUM_CHAR-1:0] vel_y,
    output logic [3*NUM_CHAR-1:0]                char_display_id,
    output logic [NUM_CHAR-1:0]                  walk_frame,
    output logic [NUM_CHAR-1:0]                  facing_left
);

    logic                                 clk_d1_q, clk_d2_q;
    logic [3*NUM_CHAR-1:0]                state_q;
    logic [SIGNED_PHY_WIDTH*NUM_CHAR-1:0] vel_q;
    logic                                 w_tick;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_d1_q <= 1'b0;
            clk_d2_q <= 1'b0;
            state_q  <= '0;
            vel_q    <= '0;
        end else begin
            clk_d1_q <= character_clk;
            clk_d2_q <= clk_d1_q;
            state_q  <= char_state;
            vel_q    <= vel_y;
        end
    end

    // One sys_clk wide per character_clk rising edge, aligned with the
    // registered state and velocity captured on the same edge.
    assign w_tick = clk_d1_q & ~clk_d2_q;

    for (genvar i = 0; i < NUM_CHAR; i++) begin : g_chan
        char_anim_fsm #(
            .SIGNED_PHY_WIDTH (SIGNED_PHY_WIDTH),
            .IDLE_PERIOD      (IDLE_PERIOD),
            .LAND_HOLD_TICKS  (LAND_HOLD_TICKS),
            .WALK_FRAME_TICKS (WALK_FRAME_TICKS),
            .HARD_LAND_VEL    (HARD_LAND_VEL),
            .CNT_WIDTH        (CNT_WIDTH)
        ) u_fsm (
            .clk_i         (sys_clk),
            .rst_ni        (sys_rst_n),
            .tick_i        (w_tick),
            .state_i       (state_q[3*i +: 3]),
            .vel_i         ($signed(vel_q[SIGNED_PHY_WIDTH*i +: SIGNED_PHY_WIDTH])),
            .id_o          (char_display_id[3*i +: 3]),
            .walk_frame_o  (walk_frame[i]),
            .facing_left_o (facing_left[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_char_anim_state_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_anim_state_controller
// Description : Directed scenarios plus randomized ticks compared against a
//               rule-level behavioural model of each animation channel.
// Config      : CHAR_ANIM_LAND_CANCEL_EN - selects landing-cancel expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_anim_state_controller;

    localparam int W = 17;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          character_clk = 1'b0;
    logic [5:0]    char_state = '0;
    logic [2*W-1:0] vel_y = '0;
    logic [5:0]    char_display_id;
    logic [1:0]    walk_frame;
    logic [1:0]    facing_left;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one entry per channel
    int m_id[2], m_idle[2], m_land[2], m_walk[2], m_frame[2], m_face[2], m_vland[2];

    char_anim_state_controller dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .character_clk   (character_clk),
        .char_state      (char_state),
        .vel_y           (vel_y),
        .char_display_id (char_display_id),
        .walk_frame      (walk_frame),
        .facing_left     (facing_left)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int dut_id(input int ch);
        return int'(char_display_id[3*ch +: 3]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_id[c] = 0; m_idle[c] = 0; m_land[c] = 0; m_walk[c] = 0;
            m_frame[c] = 0; m_face[c] = 0; m_vland[c] = 0;
        end
    endtask

    // One animation step for one channel, straight from the behavioural rules
    task automatic model_chan(input int c, input int s, input int v);
        bit was_idle, was_land, hold;
        int nx;
        was_idle = (m_id[c] == 0) || (m_id[c] == 1);
        was_land = (m_id[c] == 5) || (m_id[c] == 6);
        hold     = was_land && (m_land[c] < 63);
        nx = m_id[c];
        case (s)
            0: nx = hold ? m_id[c] : (v > 0) ? 3 : (v < 0) ? 4 : (m_idle[c] < 32) ? 0 : 1;
            1: begin nx = 7; m_face[c] = 1; end
            2: begin nx = 7; m_face[c] = 0; end
`ifdef CHAR_ANIM_LAND_CANCEL_EN
            3: nx = 2;
`else
            3: nx = hold ? m_id[c] : 2;
`endif
            4, 5: nx = (v > 0) ? 3 : (v < 0) ? 4 : m_id[c];
            6: nx = (m_vland[c] == 0) ? m_id[c] : (m_vland[c] < -7) ? 5 : 6;
            default: nx = m_id[c];
        endcase
        m_idle[c] = ((nx == 0 || nx == 1) && was_idle) ? (m_idle[c] + 1) % 64 : 0;
        m_land[c] = ((nx == 5 || nx == 6) && was_land) ? ((m_land[c] < 63) ? m_land[c] + 1 : 63) : 0;
        if (nx == 7) begin
            if (m_walk[c] == 7) begin m_walk[c] = 0; m_frame[c] ^= 1; end
            else m_walk[c]++;
        end else begin
            m_walk[c] = 0; m_frame[c] = 0;
        end
        if (v != 0) m_vland[c] = v;
        m_id[c] = nx;
    endtask

    // Present inputs with a character_clk rising edge held for high_cyc cycles
    task automatic pulse(input int s0, input int v0, input int s1, input int v1, input int high_cyc);
        @(negedge sys_clk);
        char_state    = {3'(s1), 3'(s0)};
        vel_y         = {W'(v1), W'(v0)};
        character_clk = 1'b1;
        repeat (high_cyc) @(negedge sys_clk);
        character_clk = 1'b0;
        repeat (2) @(negedge sys_clk);
        model_chan(0, s0, v0);
        model_chan(1, s1, v1);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        checks++;
        if (char_display_id !== 6'd0) begin
            errors++; $display("FAIL reset_id: got %h expected 00", char_display_id);
        end
        checks++;
        if (walk_frame !== 2'b00) begin
            errors++; $display("FAIL reset_walk: got %b expected 00", walk_frame);
        end
        checks++;
        if (facing_left !== 2'b00) begin
            errors++; $display("FAIL reset_facing: got %b expected 00", facing_left);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_idle_breath();
        int exp_id;
        for (int k = 1; k <= 96; k++) begin
            pulse(0, 0, 0, 0, 1);
            exp_id = (k <= 32 || k >= 65) ? 0 : 1;
            checks++;
            if (dut_id(0) !== exp_id || dut_id(1) !== exp_id) begin
                errors++;
                $display("FAIL idle_breath tick %0d: got %0d/%0d expected %0d", k, dut_id(0), dut_id(1), exp_id);
            end
        end
    endtask

    task automatic test_hard_land();
        int n;
        pulse(4, 5, 0, 0, 1);
        checks++;
        if (dut_id(0) !== 3) begin errors++; $display("FAIL jump_up: got %0d expected 3", dut_id(0)); end
        pulse(4, -9, 0, 0, 1);
        checks++;
        if (dut_id(0) !== 4) begin errors++; $display("FAIL jump_down: got %0d expected 4", dut_id(0)); end
        pulse(6, 0, 0, 0, 1);
        checks++;
        if (dut_id(0) !== 5) begin errors++; $display("FAIL hard_land: got %0d expected 5", dut_id(0)); end
        n = 0;
        for (int k = 0; k < 100; k++) begin
            pulse(0, 0, 0, 0, 1);
            if (dut_id(0) != 5) break;
            n++;
        end
        checks++;
        if (n !== 63 || dut_id(0) !== 0) begin
            errors++; $display("FAIL land_hold: got %0d extra ticks then id %0d expected 63 then 0", n, dut_id(0));
        end
    endtask

    task automatic test_soft_land();
        pulse(2, 0, 4, -7, 1);
        pulse(2, 0, 6, 0, 1);
        checks++;
        if (dut_id(1) !== 6) begin errors++; $display("FAIL soft_land: got %0d expected 6", dut_id(1)); end
        checks++;
        if (dut_id(0) !== 7 || facing_left[0] !== 1'b0) begin
            errors++; $display("FAIL right_walk: got id %0d facing %b expected 7 0", dut_id(0), facing_left[0]);
        end
    endtask

    task automatic test_walk();
        int exp_f;
        pulse(0, 0, 7, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            pulse(1, 0, 7, 0, 1);
            exp_f = (k >= 8 && k < 16) ? 1 : 0;
            checks++;
            if (walk_frame[0] !== 1'(exp_f) || dut_id(0) !== 7 || facing_left[0] !== 1'b1) begin
                errors++;
                $display("FAIL walk tick %0d: got frame %b id %0d facing %b expected %0d 7 1",
                         k, walk_frame[0], dut_id(0), facing_left[0], exp_f);
            end
        end
        pulse(0, 0, 7, 0, 1);
        checks++;
        if (walk_frame[0] !== 1'b0 || facing_left[0] !== 1'b1) begin
            errors++; $display("FAIL walk_exit: got frame %b facing %b expected 0 1", walk_frame[0], facing_left[0]);
        end
    endtask

    task automatic test_charge();
        int n;
        pulse(4, -9, 0, 0, 1);
        pulse(6, 0, 0, 0, 1);
        repeat (10) pulse(0, 0, 0, 0, 1);
`ifdef CHAR_ANIM_LAND_CANCEL_EN
        pulse(3, 0, 0, 0, 1);
        checks++;
        if (dut_id(0) !== 2) begin errors++; $display("FAIL charge_cancel: got %0d expected 2", dut_id(0)); end
`else
        n = 0;
        for (int k = 0; k < 100; k++) begin
            pulse(3, 0, 0, 0, 1);
            if (dut_id(0) != 5) break;
            n++;
        end
        checks++;
        if (n !== 53 || dut_id(0) !== 2) begin
            errors++; $display("FAIL charge_hold: got %0d held ticks then id %0d expected 53 then 2", n, dut_id(0));
        end
`endif
    endtask

    task automatic test_hold_high();
        pulse(0, 0, 0, 0, 1);
        pulse(1, 0, 0, 0, 100);
        checks++;
        if (dut_id(0) !== 7 || walk_frame[0] !== 1'b0) begin
            errors++; $display("FAIL hold_high: got id %0d frame %b expected 7 0", dut_id(0), walk_frame[0]);
        end
        repeat (6) pulse(1, 0, 0, 0, 1);
        checks++;
        if (walk_frame[0] !== 1'b0) begin errors++; $display("FAIL hold_high_t7: got %b expected 0", walk_frame[0]); end
        pulse(1, 0, 0, 0, 1);
        checks++;
        if (walk_frame[0] !== 1'b1) begin errors++; $display("FAIL hold_high_t8: got %b expected 1", walk_frame[0]); end
    endtask

    task automatic test_reset_mid_hold();
        pulse(4, -9, 1, 0, 1);
        pulse(6, 0, 1, 0, 1);
        @(negedge sys_clk);
        char_state    = '0;
        vel_y         = '0;
        character_clk = 1'b1;
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (char_display_id !== 6'd0 || walk_frame !== 2'b00 || facing_left !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got id %h frame %b facing %b expected 00 00 00",
                     char_display_id, walk_frame, facing_left);
        end
        character_clk = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        pulse(6, 0, 6, 0, 1);
        checks++;
        if (char_display_id !== 6'd0) begin
            errors++; $display("FAIL post_reset_fall: got %h expected 00", char_display_id);
        end
    endtask

    task automatic test_random();
        int s[2], v[2];
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 2; c++) begin
                s[c] = int'($urandom_range(0, 7));
                v[c] = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(0, 20)) - 10;
            end
            pulse(s[0], v[0], s[1], v[1], int'($urandom_range(1, 3)));
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (dut_id(c) !== m_id[c] || walk_frame[c] !== 1'(m_frame[c]) || facing_left[c] !== 1'(m_face[c])) begin
                    errors++;
                    $display("FAIL random tick %0d ch%0d: got id %0d frame %b facing %b expected %0d %0d %0d",
                             k, c, dut_id(c), walk_frame[c], facing_left[c], m_id[c], m_frame[c], m_face[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_breath();
        test_hard_land();
        test_soft_land();
        test_walk();
        test_charge();
        test_hold_high();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
